// File: rtl/cic_output_stage.sv
// Output stage behind the CIC decimator: strobe edge detect, round/shift/saturate
// gain compensation, and a first-word fall-through FIFO on a valid/ready stream.
module cic_output_stage #(
    parameter int Y_WIDTH   = 12,
    parameter int OUT_WIDTH = 12,
    parameter int SHIFT     = 4,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enabled,
    input  logic                         strobe_in,
    input  logic [Y_WIDTH-1:0]           y_in,
    output logic [OUT_WIDTH-1:0]         m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [15:0]                  drop_count,
    input  logic                         clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RW    = Y_WIDTH + 1;

    // Half an output LSB; evaluates to zero when SHIFT is 0.
    localparam logic signed [RW-1:0] ROUND = RW'((2 ** SHIFT) / 2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   strobe_q,     strobe_d;
    logic                   s1_valid_q,   s1_valid_d;
    logic [Y_WIDTH-1:0]     s1_data_q,    s1_data_d;
    logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0]       level_q,      level_d;
    logic                   overflow_q,   overflow_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [OUT_WIDTH-1:0]   mem_q [DEPTH];

    logic                   capture;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;
    logic [15:0]            drop_base;

    logic signed [RW-1:0]        t_s2;
    logic signed [RW-1:0]        r_s2;
    logic signed [OUT_WIDTH-1:0] comp_s2;

    // ------------------------------------------------------------------
    // Gain compensation, combinational from the stage-1 register
    // ------------------------------------------------------------------
    assign t_s2 = {s1_data_q[Y_WIDTH-1], s1_data_q} + ROUND;
    assign r_s2 = t_s2 >>> SHIFT;

    generate
        if (OUT_WIDTH >= RW) begin : g_extend
            assign comp_s2 = OUT_WIDTH'(r_s2);
        end else begin : g_saturate
            localparam logic signed [RW-1:0] MAX_R = RW'((2 ** (OUT_WIDTH - 1)) - 1);
            localparam logic signed [RW-1:0] MIN_R = ~MAX_R;

            always_comb begin
                comp_s2 = r_s2[OUT_WIDTH-1:0];
                if (r_s2 > MAX_R) begin
                    comp_s2 = MAX_R[OUT_WIDTH-1:0];
                end else if (r_s2 < MIN_R) begin
                    comp_s2 = MIN_R[OUT_WIDTH-1:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign capture = strobe_in & ~strobe_q & enabled;
    assign m_valid = (level_q != '0);
    assign pop     = m_valid & m_ready;
    assign full    = (level_q == LVL_W'(DEPTH));
    // A full FIFO still accepts the write when a pop frees the head slot.
    assign wr_en   = s1_valid_q & (~full | pop);
    assign drop    = s1_valid_q & full & ~pop;

    always_comb begin
        strobe_d     = strobe_in;
        s1_valid_d   = capture;
        s1_data_d    = s1_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q + LVL_W'(wr_en) - LVL_W'(pop);
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        drop_base    = drop_count_q;

        if (capture) begin
            s1_data_d = y_in;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A drop coinciding with a clear leaves exactly one drop recorded.
        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_base  = '0;
        end
        drop_count_d = drop_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_base != 16'hFFFF) begin
                drop_count_d = drop_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            strobe_q     <= strobe_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= comp_s2;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
